// File: rtl/bcd_counter_chain_if.sv
// ---------------------------------------------------------------------------
// bcd_counter_chain_if
// Control/status bundle for the multi-digit BCD counter.
//   master : drives clr, load, load_val, enable, up, limit;
//            observes count, tc, ovf, load_err
//   slave  : the counter itself (inverse directions)
// There is no valid/ready handshake on this bundle. Every control input is
// sampled on each rising clock edge, and every status output is valid in
// every cycle.
// ---------------------------------------------------------------------------
interface bcd_counter_chain_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         enable;
    logic         up;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf;
    logic         load_err;

    modport master (
        output clr, load, load_val, enable, up, limit,
        input  count, tc, ovf, load_err
    );

    modport slave (
        input  clr, load, load_val, enable, up, limit,
        output count, tc, ovf, load_err
    );
endinterface

// File: rtl/bcd_counter_chain.sv
// ---------------------------------------------------------------------------
// bcd_counter_chain
// Up/down counter made of DIGITS cascaded decimal digits. The count runs
// against an inclusive, programmable BCD limit. WRAP selects the behaviour
// at the boundary: 1 = wrap, 0 = saturate.
//   clk, rst_n : rising-edge clock; asynchronous active-low reset
//   bus.slave  : clr/load/load_val/enable/up/limit in;
//                count/tc/ovf/load_err out
// Priority per edge: clr > load > enable > hold.
// tc is combinational. ovf and load_err are registered one-cycle pulses.
// ---------------------------------------------------------------------------
module bcd_counter_chain #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_counter_chain_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] lim_s;
    logic [W-1:0] load_s;
    logic         load_bad;
    logic         at_top;
    logic         at_zero;
    logic         above;

    // Replace every non-BCD digit with 'sub'. Also flags whether any digit
    // was replaced.
    function automatic logic [W:0] sanitize(input logic [W-1:0] v,
                                            input logic [3:0]   sub);
        logic [W-1:0] r;
        logic         bad;
        r   = v;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                r[4*k +: 4] = sub;
                bad         = 1'b1;
            end
        end
        return {bad, r};
    endfunction

    // The carry moves into digit k+1 only while every lower digit rolls 9->0.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // The borrow moves into digit k+1 only while every lower digit rolls 0->9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W:0] lim_full;
    logic [W:0] load_full;

    always_comb begin
        lim_full  = sanitize(bus.limit, 4'd9);
        load_full = sanitize(bus.load_val, 4'd0);
        lim_s     = lim_full[W-1:0];
        load_s    = load_full[W-1:0];
        load_bad  = load_full[W];
        // Both operands hold only valid BCD digits. A plain unsigned compare
        // of the packed vectors therefore equals a numeric decimal compare.
        at_top    = (count_q >= lim_s);
        above     = (count_q > lim_s);
        at_zero   = (count_q == '0);
    end

    always_comb begin
        count_d    = count_q;
        ovf_d      = 1'b0;
        load_err_d = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d    = load_s;
            load_err_d = load_bad;
        end else if (bus.enable) begin
            if (bus.up) begin
                if (at_top) begin
                    count_d = WRAP ? '0 : count_q;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = bcd_inc(count_q);
                end
            end else begin
                if (at_zero) begin
                    count_d = WRAP ? lim_s : count_q;
                    ovf_d   = 1'b1;
                end else if (above) begin
                    // A count above the limit re-enters the range at the
                    // limit. This is not a boundary event, so ovf stays low.
                    count_d = lim_s;
                end else begin
                    count_d = bcd_dec(count_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;
    assign bus.load_err = load_err_q;
    assign bus.tc       = bus.up ? at_top : at_zero;
endmodule

// File: tb/tb_bcd_counter_chain.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_chain
// Directed bench with three counter instances:
//   u_2w : DIGITS=2, WRAP=1
//   u_2s : DIGITS=2, WRAP=0
//   u_3w : DIGITS=3, WRAP=1
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point.
// ---------------------------------------------------------------------------
module tb_bcd_counter_chain;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    bcd_counter_chain_if #(.DIGITS(2)) b2w ();
    bcd_counter_chain_if #(.DIGITS(2)) b2s ();
    bcd_counter_chain_if #(.DIGITS(3)) b3w ();

    bcd_counter_chain #(.DIGITS(2), .WRAP(1'b1)) u_2w (.clk(clk), .rst_n(rst_n), .bus(b2w));
    bcd_counter_chain #(.DIGITS(2), .WRAP(1'b0)) u_2s (.clk(clk), .rst_n(rst_n), .bus(b2s));
    bcd_counter_chain #(.DIGITS(3), .WRAP(1'b1)) u_3w (.clk(clk), .rst_n(rst_n), .bus(b3w));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] e;
        int          tens;
        int          ones;
        checks = 0;
        errors = 0;
        {b2w.clr, b2w.load, b2w.load_val, b2w.enable, b2w.up, b2w.limit} = '0;
        {b2s.clr, b2s.load, b2s.load_val, b2s.enable, b2s.up, b2s.limit} = '0;
        {b3w.clr, b3w.load, b3w.load_val, b3w.enable, b3w.up, b3w.limit} = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(b2w.count), 32'h00);
        chk("rst_ovf", 32'(b2w.ovf), 32'h0);
        chk("rst_load_err", 32'(b3w.load_err), 32'h0);
        #10 rst_n = 1'b1;
        step();

        // Test 1: 2-digit wrap, limit 59, continuous up count from 00
        b2w.limit  = 8'h59;
        b2w.up     = 1'b1;
        #1;
        chk("t1_tc_at0", 32'(b2w.tc), 32'h0);
        b2w.enable = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tens = (n % 60) / 10;
            ones = (n % 60) % 10;
            exp_q.push_back(32'((tens << 4) | ones));
        end
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            chk("t1_count", 32'(b2w.count), e);
            chk("t1_tc", 32'(b2w.tc), (e == 32'h59) ? 32'h1 : 32'h0);
            chk("t1_ovf", 32'(b2w.ovf), (e == 32'h00) ? 32'h1 : 32'h0);
            chk("t1_digit0_bcd", 32'(b2w.count[3:0] <= 4'd9), 32'h1);
        end
        b2w.enable = 1'b0;
        step();
        chk("t1_hold", 32'(b2w.count), 32'h00);
        chk("t1_ovf_clear", 32'(b2w.ovf), 32'h0);

        // Test 2: saturate, down from 03, hold at 00, then turn around
        b2s.limit    = 8'h59;
        b2s.load     = 1'b1;
        b2s.load_val = 8'h03;
        step();
        chk("t2_load", 32'(b2s.count), 32'h03);
        chk("t2_load_err", 32'(b2s.load_err), 32'h0);
        b2s.load   = 1'b0;
        b2s.up     = 1'b0;
        b2s.enable = 1'b1;
        step();
        chk("t2_dn02", 32'(b2s.count), 32'h02);
        step();
        chk("t2_dn01", 32'(b2s.count), 32'h01);
        step();
        chk("t2_dn00", 32'(b2s.count), 32'h00);
        chk("t2_dn00_ovf", 32'(b2s.ovf), 32'h0);
        chk("t2_tc_down0", 32'(b2s.tc), 32'h1);
        step();
        chk("t2_sat_hold", 32'(b2s.count), 32'h00);
        chk("t2_sat_ovf", 32'(b2s.ovf), 32'h1);
        step();
        chk("t2_sat_hold2", 32'(b2s.count), 32'h00);
        chk("t2_sat_ovf2", 32'(b2s.ovf), 32'h1);
        b2s.up = 1'b1;
        step();
        chk("t2_up01", 32'(b2s.count), 32'h01);
        chk("t2_up_ovf", 32'(b2s.ovf), 32'h0);
        b2s.enable = 1'b0;

        // Test 3: 3 digits, borrow chain and wrap down to the limit
        b3w.limit    = 12'h999;
        b3w.load     = 1'b1;
        b3w.load_val = 12'h100;
        step();
        chk("t3_load100", 32'(b3w.count), 32'h100);
        b3w.load   = 1'b0;
        b3w.enable = 1'b1;
        b3w.up     = 1'b0;
        step();
        chk("t3_borrow", 32'(b3w.count), 32'h099);
        b3w.enable   = 1'b0;
        b3w.load     = 1'b1;
        b3w.load_val = 12'h000;
        step();
        b3w.load   = 1'b0;
        b3w.enable = 1'b1;
        step();
        chk("t3_wrap_dn", 32'(b3w.count), 32'h999);
        chk("t3_wrap_ovf", 32'(b3w.ovf), 32'h1);
        step();
        chk("t3_998", 32'(b3w.count), 32'h998);
        chk("t3_ovf_pulse", 32'(b3w.ovf), 32'h0);

        // Loads: non-BCD digit, load with clr, load with enable
        b3w.enable   = 1'b0;
        b3w.load     = 1'b1;
        b3w.load_val = 12'h3A7;
        step();
        chk("ld_fix", 32'(b3w.count), 32'h307);
        chk("ld_err", 32'(b3w.load_err), 32'h1);
        b3w.load = 1'b0;
        step();
        chk("ld_err_pulse", 32'(b3w.load_err), 32'h0);
        chk("ld_hold", 32'(b3w.count), 32'h307);
        b3w.load = 1'b1;
        b3w.clr  = 1'b1;
        step();
        chk("ld_clr_count", 32'(b3w.count), 32'h000);
        chk("ld_clr_err", 32'(b3w.load_err), 32'h0);
        b3w.clr      = 1'b0;
        b3w.enable   = 1'b1;
        b3w.up       = 1'b1;
        b3w.load_val = 12'h456;
        step();
        chk("ld_en", 32'(b3w.count), 32'h456);
        b3w.load   = 1'b0;
        b3w.enable = 1'b0;

        // Non-BCD limit digit 0x2F counts as 29
        b2w.limit    = 8'h2F;
        b2w.load     = 1'b1;
        b2w.load_val = 8'h28;
        step();
        b2w.load   = 1'b0;
        b2w.up     = 1'b1;
        b2w.enable = 1'b1;
        step();
        chk("nlim_29", 32'(b2w.count), 32'h29);
        chk("nlim_tc", 32'(b2w.tc), 32'h1);
        step();
        chk("nlim_wrap", 32'(b2w.count), 32'h00);
        chk("nlim_ovf", 32'(b2w.ovf), 32'h1);

        // Test 4: limit lowered below the count
        b2w.enable   = 1'b0;
        b2w.limit    = 8'h20;
        b2w.load     = 1'b1;
        b2w.load_val = 8'h45;
        step();
        chk("t4_load45", 32'(b2w.count), 32'h45);
        b2w.load   = 1'b0;
        b2w.enable = 1'b1;
        step();
        chk("t4_up_wrap", 32'(b2w.count), 32'h00);
        chk("t4_up_ovf", 32'(b2w.ovf), 32'h1);
        b2w.enable = 1'b0;
        b2w.load   = 1'b1;
        step();
        b2w.load = 1'b0;
        b2w.up   = 1'b0;
        #1;
        chk("t4_tc_dn", 32'(b2w.tc), 32'h0);
        b2w.enable = 1'b1;
        step();
        chk("t4_reenter", 32'(b2w.count), 32'h20);
        chk("t4_reenter_ovf", 32'(b2w.ovf), 32'h0);

        // Test 5: asynchronous reset mid-count, enable held through release
        b2w.limit    = 8'h59;
        b2w.up       = 1'b1;
        b2w.load     = 1'b1;
        b2w.load_val = 8'h37;
        step();
        chk("t5_load37", 32'(b2w.count), 32'h37);
        b2w.load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_count", 32'(b2w.count), 32'h00);
        chk("t5_async_ovf", 32'(b2w.ovf), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t5_first_edge", 32'(b2w.count), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Parametrised multi-digit BCD counter, successor to the single-digit decade counter. Counts up or down across DIGITS cascaded decimal digits against a programmable BCD limit, with synchronous clear, synchronous load, wrap or saturate mode, terminal-count and overflow indication. Used for timers, display counters and event tallies (e.g. 00–59 seconds, 000–999 frames) in place of hand-chained decade counters.

## Interface
- DIGITS, 4, number of BCD digits (1–8); count width W = 4*DIGITS
- WRAP, 1, 1 = wrap at boundary; 0 = saturate at boundary
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous load of load_val
- load_val  in  W  BCD value to load
- enable  in  1  count enable
- up  in  1  direction: 1 = up, 0 = down
- limit  in  W  BCD upper bound (inclusive); sampled every cycle
- count  out  W  current BCD value, digit 0 in bits [3:0]
- tc  out  1  terminal count, combinational
- ovf  out  1  registered one-cycle boundary pulse
- load_err  out  1  registered one-cycle pulse: load_val contained a non-BCD digit

## Operation
- Priority per cycle: clr > load > enable; with none asserted, count holds.
- clr: count <= 0; ovf <= 0; load_err <= 0.
- load: each digit of load_val > 9 replaced by 0, others loaded as-is; load_err <= 1 if any digit replaced, else 0. Loaded value may exceed limit; no clamping on load. ovf <= 0.
- enable, up = 1:
  - count >= limit (numeric BCD compare): WRAP=1 -> count <= 0; WRAP=0 -> hold. ovf <= 1 in both modes.
  - else: BCD increment; digit k rolls 9 -> 0 and carries into digit k+1 only when all lower digits are 9.
- enable, up = 0:
  - count == 0: WRAP=1 -> count <= limit; WRAP=0 -> hold. ovf <= 1.
  - count > limit: count <= limit, ovf <= 0 (re-entry into range).
  - else: BCD decrement; digit 0 -> 9 with borrow from digit k+1.
- tc = (up && count >= limit) || (!up && count == 0). Independent of enable.
- Non-BCD limit digits: treated as 9 for compare and wrap-down load.
- limit == 0: up -> tc permanently 1, wraps/holds at 0 every enabled cycle with ovf each cycle; down behaves identically.
- Direction change takes effect on the same edge; no pipeline state.
- ovf and load_err are 0 in every cycle not listed above.

## Timing
- Reset (rst_n low, asynchronous): count = 0, ovf = 0, load_err = 0 immediately; released synchronously to next clk edge.
- Reset mid-count discards value; first enabled edge after release yields 1 (up) or limit/hold per mode (down).
- Latency: count, ovf, load_err update 1 cycle after the qualifying edge; tc follows count and up/limit combinationally in the same cycle.
- ovf asserts in the cycle after the edge where the boundary transition occurs, concurrent with the wrapped/held count.
- Continuous enable at terminal in saturate mode: ovf high every cycle while held.
- Carry chain is combinational across all digits within one cycle; no multi-cycle ripple.

## Test plan
- DIGITS=2, WRAP=1, limit=0x59, up, enable continuous from 0: count 0x00..0x09, 0x10 ..., 0x59, 0x00; tc high only at 0x59; ovf single pulse coincident with 0x00; digit 0 never exceeds 9.
- DIGITS=2, WRAP=0, limit=0x59, down from load 0x03: 0x02, 0x01, 0x00, then hold 0x00 with ovf high every enabled cycle; switch up -> 0x01, ovf low.
- DIGITS=3, WRAP=1, limit=0x999, down from 0x100 -> 0x099; from 0x000 -> 0x999 with ovf pulse.
- Load 0x3A7 (DIGITS=3): count = 0x307, load_err one-cycle pulse; load+clr same cycle -> count 0, load_err 0; load+enable same cycle -> loaded value, no increment.
- Limit lowered to 0x20 while count=0x45, DIGITS=2, WRAP=1: up -> 0x00 with ovf; repeat from 0x45 down -> 0x20, ovf 0.
- Assert rst_n low mid-count (count=0x37) between edges: count 0 immediately, ovf 0; enable held through release -> 0x01 on first edge after release.
